spi_slave_core: RTL and testbench

Synthesizable, parametrised SPI slave that replaces fixed 8-bit, per-mode simulation receivers with a single clocked block. It runs on the system clock, oversamples `sck`/`csn`/`mosi` through synchronisers, and supports all four CPOL/CPHA modes, selectable per frame. Words are `DATA_W` bits, multi-word frames are supported, and data moves to and from the core over valid/ready handshakes. It sits between the chip pads and a register/DMA bridge.

---
 rtl/spi_slave_core.sv | 211 +++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core
// SPI slave running on the system clock. sck/csn/mosi are synchronised and
// edge-detected; CPOL/CPHA are latched at each frame start. Words of DATA_W
// bits move to/from the core over valid/ready handshakes through a one-word
// TX buffer and a one-word RX holding register.
//
// Ports:
//   clk, resetn            system clock, async active-low reset
//   cpol, cpha             SPI mode, latched when csn falls
//   sck, csn, mosi         asynchronous pad inputs
//   miso, miso_oe          registered pad outputs
//   tx_data/valid/ready    TX word handshake into the one-word buffer
//   rx_data/valid/ready    RX word handshake out of the holding register
//   tx_underrun            pulse: word load found the TX buffer empty
//   rx_overrun             pulse: word completed while rx_valid was held
//   frame_abort            pulse: csn rose with a partial word
module spi_slave_core #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sck,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_underrun,
    output logic              rx_overrun,
    output logic              frame_abort
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic sck_s, csn_s, mosi_s, sck_d, csn_d;
    logic cpol_q, cpha_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] tx_sr, buf_q;
    logic buf_full;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] rx_word;

    logic csn_fall, csn_rise, sck_rise, sck_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic start, stop, sample, shift, load, word_done, tx_write;

    // Synchronisers; reset to 0 so a csn held low across reset does not
    // look like a fresh frame start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync  <= '0;
            csn_sync  <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            csn_d     <= csn_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign csn_fall = csn_d & ~csn_s;
    assign csn_rise = ~csn_d & csn_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (csn_fall) state_next = ACTIVE;
            ACTIVE:  if (csn_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: per-cycle datapath controls
    always_comb begin
        start  = 1'b0;
        stop   = 1'b0;
        sample = 1'b0;
        shift  = 1'b0;
        load   = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    start = 1'b1;
                    load  = ~cpha;   // live input: cpha_q is latched this cycle
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    stop = 1'b1;
                end else if (sample_edge) begin
                    sample = 1'b1;
                end else if (shift_edge) begin
                    // bit_cnt==0 on a shift edge is the word boundary in both
                    // phases: after the last sample (CPHA=0) or before the
                    // first sample (CPHA=1).
                    if (bit_cnt == '0) load  = 1'b1;
                    else               shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign word_done = sample && (bit_cnt == LAST);
    assign rx_word   = {rx_sr, mosi_s};
    assign tx_write  = tx_valid && !buf_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;

            if (start) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                bit_cnt <= '0;
            end

            if (stop) begin
                if (bit_cnt != '0) frame_abort <= 1'b1;
                bit_cnt <= '0;
            end

            if (sample) begin
                rx_sr   <= rx_word[DATA_W-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end

            // Completion in the same cycle as acceptance refills the slot.
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else begin
                if (word_done)            rx_overrun <= 1'b1;
                if (rx_valid && rx_ready) rx_valid   <= 1'b0;
            end

            if (load) begin
                if (buf_full) begin
                    tx_sr <= buf_q;
                end else begin
                    tx_sr       <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (shift) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end

            // A write racing a load into an empty buffer lands after the
            // load has already underrun.
            if (tx_write) buf_q <= tx_data;
            if (load && buf_full) buf_full <= 1'b0;
            else if (tx_write)    buf_full <= 1'b1;
        end
    end

    assign miso     = tx_sr[DATA_W-1];
    assign miso_oe  = (state == ACTIVE);
    assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: an 8-bit instance and a 16-bit instance
// share clock, reset, sck, mosi and mode pins; each has its own csn.
module tb_spi_slave_core;

    localparam int HALF = 8;   // sck half-period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, cpol, cpha, sck, mosi, csn8, csn16;

    logic       miso8, oe8, txv8, txr8, rxv8, rxr8, unr8_p, ovr8_p, abt8_p;
    logic [7:0] txd8, rxd8;
    logic        miso16, oe16, txv16, txr16, rxv16, rxr16, unr16_p, ovr16_p, abt16_p;
    logic [15:0] txd16, rxd16;

    int total = 0, bad = 0;
    int unr8 = 0, ovr8 = 0, abt8 = 0, rise8 = 0;
    int unr16 = 0, ovr16 = 0, abt16 = 0;
    logic rv8_d = 1'b0;
    logic [15:0] q16[$];

    spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) u8 (
        .clk(clk), .resetn(resetn), .cpol(cpol), .cpha(cpha),
        .sck(sck), .csn(csn8), .mosi(mosi), .miso(miso8), .miso_oe(oe8),
        .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
        .rx_data(rxd8), .rx_valid(rxv8), .rx_ready(rxr8),
        .tx_underrun(unr8_p), .rx_overrun(ovr8_p), .frame_abort(abt8_p)
    );

    spi_slave_core #(.DATA_W(16), .SYNC_STAGES(2)) u16 (
        .clk(clk), .resetn(resetn), .cpol(cpol), .cpha(cpha),
        .sck(sck), .csn(csn16), .mosi(mosi), .miso(miso16), .miso_oe(oe16),
        .tx_data(txd16), .tx_valid(txv16), .tx_ready(txr16),
        .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rxr16),
        .tx_underrun(unr16_p), .rx_overrun(ovr16_p), .frame_abort(abt16_p)
    );

    always @(posedge clk) begin
        rv8_d <= rxv8;
        if (rxv8 && !rv8_d) rise8 <= rise8 + 1;
        if (unr8_p)  unr8  <= unr8 + 1;
        if (ovr8_p)  ovr8  <= ovr8 + 1;
        if (abt8_p)  abt8  <= abt8 + 1;
        if (unr16_p) unr16 <= unr16 + 1;
        if (ovr16_p) ovr16 <= ovr16 + 1;
        if (abt16_p) abt16 <= abt16 + 1;
        if (rxv16 && rxr16) q16.push_back(rxd16);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_begin(input bit w16, input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sck  = pol;
        wait_half();
        if (w16) csn16 = 1'b0;
        else     csn8  = 1'b0;
    endtask

    task automatic frame_end();
        wait_half();
        csn8  = 1'b1;
        csn16 = 1'b1;
        wait_half();
    endtask

    // Master side: sends dout[nbits-1:0] MSB first, returns captured miso bits.
    task automatic xfer(input bit w16, input int nbits, input logic [15:0] dout,
                        output logic [15:0] din);
        din = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = dout[i];
                wait_half();
                din = {din[14:0], (w16 ? miso16 : miso8)};
                sck = ~sck;
                wait_half();
                sck = ~sck;
            end else begin
                wait_half();
                sck  = ~sck;
                mosi = dout[i];
                wait_half();
                din = {din[14:0], (w16 ? miso16 : miso8)};
                sck = ~sck;
            end
        end
    endtask

    task automatic write_tx(input bit w16, input logic [15:0] v);
        int n = 0;
        while (!(w16 ? txr16 : txr8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", 32'(n < 50), 32'd1);
        if (w16) begin txd16 = v;      txv16 = 1'b1; end
        else     begin txd8  = v[7:0]; txv8  = 1'b1; end
        @(negedge clk);
        txv8  = 1'b0;
        txv16 = 1'b0;
    endtask

    task automatic accept8();
        rxr8 = 1'b1;
        @(negedge clk);
        rxr8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] d0, d1, d2, qv;
        int r0, u0, o0, a0, u16s, o16s, a16s;

        resetn = 1'b0; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; mosi = 1'b0;
        csn8 = 1'b1; csn16 = 1'b1;
        txv8 = 1'b0; txd8 = '0; rxr8 = 1'b0;
        txv16 = 1'b0; txd16 = '0; rxr16 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_miso", miso8, 0);
        chk("rst_oe", oe8, 0);
        chk("rst_tx_ready", txr8, 1);
        chk("rst_rx_data", rxd8, 0);
        chk("rst_rx_valid", rxv8, 0);
        chk("rst_pulses", {unr8_p, ovr8_p, abt8_p}, 0);
        chk("rst_oe16", oe16, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0 single word: slave sends A5, master sends 3C
        r0 = rise8;
        write_tx(0, 16'h00A5);
        frame_begin(0, 0, 0);
        xfer(0, 8, 16'h003C, d0);
        chk("t1_oe_active", oe8, 1);
        frame_end();
        chk("t1_miso", d0, 16'h00A5);
        chk("t1_rx_data", rxd8, 8'h3C);
        chk("t1_rx_valid", rxv8, 1);
        chk("t1_rise_once", rise8 - r0, 1);
        chk("t1_oe_idle", oe8, 0);
        accept8();
        chk("t1_rx_cleared", rxv8, 0);

        // All four modes: slave 81, master 7E
        rxr8 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            r0 = rise8;
            write_tx(0, 16'h0081);
            frame_begin(0, m[1], m[0]);
            xfer(0, 8, 16'h007E, d0);
            frame_end();
            chk($sformatf("t2_m%0d_miso", m), d0, 16'h0081);
            chk($sformatf("t2_m%0d_rx_data", m), rxd8, 8'h7E);
            chk($sformatf("t2_m%0d_rise", m), rise8 - r0, 1);
        end
        rxr8 = 1'b0;

        // 16-bit mode 3, three words with TX refilled between words
        u16s = unr16; o16s = ovr16; a16s = abt16;
        write_tx(1, 16'hFEDC);
        frame_begin(1, 1, 1);
        xfer(1, 16, 16'h1234, d0);
        write_tx(1, 16'h4110);
        xfer(1, 16, 16'hBEEF, d1);
        write_tx(1, 16'h8000);
        xfer(1, 16, 16'h0001, d2);
        frame_end();
        chk("t3_miso0", d0, 16'hFEDC);
        chk("t3_miso1", d1, 16'h4110);
        chk("t3_miso2", d2, 16'h8000);
        chk("t3_rx_count", q16.size(), 3);
        for (int i = 0; i < 3; i++) begin
            qv = (i < q16.size()) ? q16[i] : 16'hDEAD;
            chk($sformatf("t3_rx%0d", i), qv,
                (i == 0) ? 16'h1234 : (i == 1) ? 16'hBEEF : 16'h0001);
        end
        chk("t3_underrun", unr16 - u16s, 0);
        chk("t3_overrun", ovr16 - o16s, 0);
        chk("t3_abort", abt16 - a16s, 0);

        // Underrun/overrun: empty TX buffer, rx_ready low, mode 1, two words
        u0 = unr8; o0 = ovr8;
        frame_begin(0, 0, 1);
        xfer(0, 8, 16'h0096, d0);
        xfer(0, 8, 16'h0069, d1);
        frame_end();
        chk("t4_miso0", d0, 0);
        chk("t4_miso1", d1, 0);
        chk("t4_underruns", unr8 - u0, 2);
        chk("t4_overruns", ovr8 - o0, 1);
        chk("t4_rx_data", rxd8, 8'h96);
        chk("t4_rx_valid", rxv8, 1);
        accept8();

        // Abort after 5 bits, then a clean frame
        a0 = abt8; r0 = rise8;
        frame_begin(0, 0, 0);
        xfer(0, 5, 16'h0015, d0);
        frame_end();
        chk("t5_abort", abt8 - a0, 1);
        chk("t5_rx_valid", rxv8, 0);
        chk("t5_no_rise", rise8 - r0, 0);
        write_tx(0, 16'h005A);
        frame_begin(0, 0, 0);
        xfer(0, 8, 16'h00C3, d0);
        frame_end();
        chk("t5_miso", d0, 16'h005A);
        chk("t5_rx_data", rxd8, 8'hC3);
        chk("t5_rx_valid_after", rxv8, 1);

        // Reset after 3 bits of a mode-0 frame; buffer refilled so tx_ready=0
        write_tx(0, 16'h0033);
        frame_begin(0, 0, 0);
        write_tx(0, 16'h0044);
        xfer(0, 3, 16'h0005, d0);
        chk("t6_pre_miso", miso8, 1);
        chk("t6_pre_oe", oe8, 1);
        chk("t6_pre_tx_ready", txr8, 0);
        resetn = 1'b0;
        csn8   = 1'b1;
        #1;
        chk("t6_miso", miso8, 0);
        chk("t6_oe", oe8, 0);
        chk("t6_tx_ready", txr8, 1);
        chk("t6_rx_data", rxd8, 0);
        chk("t6_rx_valid", rxv8, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_half();
        write_tx(0, 16'h0099);
        frame_begin(0, 0, 0);
        xfer(0, 8, 16'h0042, d0);
        frame_end();
        chk("t6_post_miso", d0, 16'h0099);
        chk("t6_post_rx_data", rxd8, 8'h42);
        chk("t6_post_rx_valid", rxv8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
